timebase_timer: RTL

TIMEBASE_TIMER -- requirements
Module: timebase_timer

---
 rtl/timebase_pkg.sv | 16 +
 rtl/timebase_timer_if.sv | 35 +++
 rtl/timer_channel.sv | 82 ++++++++
 rtl/timebase_timer.sv | 78 +++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// timebase_pkg
// Shared definitions for the timebase timer: the countdown channel state
// encoding and the default values of the block parameters.
package timebase_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int DEF_CLK_PER_TICK = 50;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_N_CH         = 4;
    localparam int DEF_TMO_W        = 24;

endpackage

// File: rtl/timebase_timer_if.sv
// timebase_timer_if
// Bundles the control and status signals of the timebase timer.
//   en, clr            timebase enable and synchronous clear
//   tick, time_count   tick pulse and free-running tick counter
//   start, stop        per-channel arm/re-arm and cancel strobes
//   timeout            per-channel duration in ticks, channel i in [i*TMO_W +: TMO_W]
//   busy, expired      per-channel counting flag and completion pulse
// master: the controlling side; slave: the timer itself.
interface timebase_timer_if #(
    parameter int CNT_W = 32,
    parameter int N_CH  = 4,
    parameter int TMO_W = 24
);

    logic                  en;
    logic                  clr;
    logic                  tick;
    logic [CNT_W-1:0]      time_count;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH*TMO_W-1:0] timeout;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       expired;

    modport master (
        output en, clr, start, stop, timeout,
        input  tick, time_count, busy, expired
    );

    modport slave (
        input  en, clr, start, stop, timeout,
        output tick, time_count, busy, expired
    );

endinterface

// File: rtl/timer_channel.sv
// timer_channel
// One countdown channel: a remaining-ticks counter plus an IDLE/RUN FSM.
//   clk, rst   clock and asynchronous active-high reset
//   tick       timebase tick, already qualified by the timebase enable
//   start      arm/re-arm strobe, samples timeout
//   stop       cancel strobe, wins over start and over the final tick
//   timeout    duration in ticks
//   busy       high while in RUN
//   expired    one-cycle pulse the cycle after the count completes
module timer_channel
    import timebase_pkg::*;
#(
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [TMO_W-1:0] timeout,
    output logic             busy,
    output logic             expired
);

    chan_state_t      state_q, state_d;
    logic [TMO_W-1:0] rem_q, rem_d;
    logic             exp_q, exp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
        end
    end

    // Priority: stop, then start, then the tick countdown. A start that
    // coincides with a tick loads the full timeout and swallows that tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;
        if (stop) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (start) begin
            if (timeout == '0) begin
                state_d = IDLE;
                rem_d   = '0;
                exp_d   = 1'b1;
            end else begin
                state_d = RUN;
                rem_d   = timeout;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        if (rem_q == TMO_W'(1)) begin
                            state_d = IDLE;
                            rem_d   = '0;
                            exp_d   = 1'b1;
                        end else begin
                            rem_d = rem_q - TMO_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign expired = exp_q;

endmodule

// File: rtl/timebase_timer.sv
// timebase_timer
// Prescaler producing a tick every CLK_PER_TICK enabled cycles, a wrapping
// tick counter, and N_CH independent countdown channels driven by the tick.
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   timebase_timer_if slave: en, clr, tick, time_count, start, stop,
//         timeout, busy, expired
// CLK_PER_TICK must be 2 or more.
module timebase_timer
    import timebase_pkg::*;
#(
    parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int N_CH         = DEF_N_CH,
    parameter int TMO_W        = DEF_TMO_W
) (
    input  logic clk,
    input  logic rst,
    timebase_timer_if.slave bus
);

    localparam int          PW   = $clog2(CLK_PER_TICK);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

    logic [PW-1:0]    presc_q;
    logic             tick_q;
    logic [CNT_W-1:0] count_q;
    logic             tick_en;
    logic [N_CH-1:0]  busy_w;
    logic [N_CH-1:0]  exp_w;

    // tick_q is only cleared on an enabled cycle, so a tick raised just
    // before en drops is held (and hidden) until en returns. That way
    // every tick counted in time_count is also seen once by the channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
        end else if (bus.clr) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
        end else if (bus.en) begin
            if (presc_q == LAST) begin
                presc_q <= '0;
                tick_q  <= 1'b1;
                count_q <= count_q + CNT_W'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
                tick_q  <= 1'b0;
            end
        end
    end

    assign tick_en        = tick_q & bus.en;
    assign bus.tick       = tick_en;
    assign bus.time_count = count_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .TMO_W(TMO_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick_en),
            .start  (bus.start[i]),
            .stop   (bus.stop[i]),
            .timeout(bus.timeout[i*TMO_W +: TMO_W]),
            .busy   (busy_w[i]),
            .expired(exp_w[i])
        );
    end

    assign bus.busy    = busy_w;
    assign bus.expired = exp_w;

endmodule
